voice_mixer: RTL and testbench

Parametrised, time-multiplexed mixer for the synth voice path. It sums NUM_VOICES one-bit square-wave voices into one saturated output sample, and supports per-voice volume, mute, unipolar or bipolar weighting, and a registered valid strobe. It sits between the voice oscillators and the DAC/PWM output stage, and replaces the flat combinational voice sum with a sample-rate-driven sequential accumulator.

---
 rtl/mixer_pkg.sv | 33 +++
 rtl/voice_vol_regs.sv | 32 +++
 rtl/voice_mixer.sv | 159 +++++++++++++++
 tb/tb_voice_mixer.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/mixer_pkg.sv
// Shared types and sizing helpers for the voice mixer.
package mixer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } mix_state_e;

  // ceil(log2(n)); returns 0 for n <= 1.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    int unsigned v;
    r = 0;
    v = (n > 0) ? n - 1 : 0;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

  // Voice index width; at least one bit so a single-voice build still has a port.
  function automatic int unsigned addr_w(input int unsigned num_voices);
    return (clog2(num_voices) == 0) ? 1 : clog2(num_voices);
  endfunction

  // Signed accumulator width: sign bit + one guard bit + growth over the voice count.
  function automatic int unsigned acc_w(input int unsigned vol_w, input int unsigned num_voices);
    return vol_w + 2 + clog2(num_voices);
  endfunction

endpackage

// File: rtl/voice_vol_regs.sv
// Per-voice volume table: synchronous write port, combinational read port.
//   clk, rst      : clock, synchronous active-high reset (table resets to all-ones)
//   we/waddr/wdata: write port; out-of-range addresses are dropped
//   raddr/rdata   : combinational read, returns the pre-write value on a same-cycle write
module voice_vol_regs #(
  parameter int unsigned NUM_VOICES = 5,
  parameter int unsigned VOL_W      = 4,
  parameter int unsigned ADDR_W     = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [VOL_W-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [VOL_W-1:0]  rdata
);

  logic [VOL_W-1:0] vol_q [NUM_VOICES];

  // Table storage.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_VOICES; i++) vol_q[i] <= '1;
    end else if (we && (32'(waddr) < NUM_VOICES)) begin
      vol_q[waddr] <= wdata;
    end
  end

  assign rdata = (32'(raddr) < NUM_VOICES) ? vol_q[raddr] : '0;

endmodule

// File: rtl/voice_mixer.sv
// Time-multiplexed mixer: one voice accumulated per cycle after sample_tick,
// then the sum is saturated into mix_out with a one-cycle mix_valid.
//   clk, rst            : clock, synchronous active-high reset
//   voice_in, mute      : voice levels and mutes, snapshotted on an accepted tick
//   sample_tick         : starts a mix when idle, otherwise pulses overrun
//   vol_we/addr/data    : volume table write port, usable in any state
//   mix_out, clip       : saturated sample and saturation flag, updated with mix_valid
//   mix_valid, busy, overrun : status
module voice_mixer
  import mixer_pkg::*;
#(
  parameter int unsigned NUM_VOICES = 5,
  parameter int unsigned VOL_W      = 4,
  parameter int unsigned OUT_W      = 8,
  parameter bit          BIPOLAR    = 1'b0
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_VOICES-1:0]           voice_in,
  input  logic [NUM_VOICES-1:0]           mute,
  input  logic                            sample_tick,
  input  logic                            vol_we,
  input  logic [addr_w(NUM_VOICES)-1:0]   vol_addr,
  input  logic [VOL_W-1:0]                vol_data,
  output logic [OUT_W-1:0]                mix_out,
  output logic                            mix_valid,
  output logic                            clip,
  output logic                            busy,
  output logic                            overrun
);

  localparam int unsigned ADDR_W = addr_w(NUM_VOICES);
  localparam int unsigned ACC_W  = acc_w(VOL_W, NUM_VOICES);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_VOICES - 1);
  localparam logic signed [31:0] SAT_HI = BIPOLAR ? (32'sd1 <<< (OUT_W - 1)) - 32'sd1
                                                  : (32'sd1 <<< OUT_W) - 32'sd1;
  localparam logic signed [31:0] SAT_LO = BIPOLAR ? -(32'sd1 <<< (OUT_W - 1)) : 32'sd0;

  mix_state_e              state_q, state_d;
  logic [ADDR_W-1:0]       idx_q, idx_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [NUM_VOICES-1:0]   voice_q, voice_d, mute_q, mute_d;
  logic [VOL_W-1:0]        vol_rd;
  logic signed [ACC_W-1:0] vol_s;
  logic signed [31:0]      acc_ext;
  logic [OUT_W-1:0]        sat_val;
  logic                    sat_clip;
  logic [OUT_W-1:0]        mix_out_d;
  logic                    mix_valid_d, clip_d, busy_d, overrun_d;

  voice_vol_regs #(
    .NUM_VOICES (NUM_VOICES),
    .VOL_W      (VOL_W),
    .ADDR_W     (ADDR_W)
  ) u_vol (
    .clk   (clk),
    .rst   (rst),
    .we    (vol_we),
    .waddr (vol_addr),
    .wdata (vol_data),
    .raddr (idx_q),
    .rdata (vol_rd)
  );

  assign vol_s = ACC_W'(vol_rd);

  // Clamp the accumulator into the output range.
  always_comb begin
    acc_ext  = 32'(acc_q);
    sat_val  = OUT_W'(acc_ext);
    sat_clip = 1'b0;
    if (acc_ext > SAT_HI) begin
      sat_val  = OUT_W'(SAT_HI);
      sat_clip = 1'b1;
    end else if (acc_ext < SAT_LO) begin
      sat_val  = OUT_W'(SAT_LO);
      sat_clip = 1'b1;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (sample_tick) state_d = ACCUM;
      ACCUM:   if (idx_q == LAST_IDX) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath and output next values.
  always_comb begin
    idx_d       = idx_q;
    acc_d       = acc_q;
    voice_d     = voice_q;
    mute_d      = mute_q;
    mix_out_d   = mix_out;
    clip_d      = clip;
    mix_valid_d = 1'b0;
    overrun_d   = sample_tick && (state_q != IDLE);
    busy_d      = (state_d != IDLE);
    case (state_q)
      IDLE: begin
        if (sample_tick) begin
          voice_d = voice_in;
          mute_d  = mute;
          acc_d   = '0;
          idx_d   = '0;
        end
      end
      ACCUM: begin
        if (!mute_q[idx_q]) begin
          if (voice_q[idx_q]) acc_d = acc_q + vol_s;
          else if (BIPOLAR)   acc_d = acc_q - vol_s;
        end
        idx_d = ADDR_W'(idx_q + 1'b1);
      end
      DONE: begin
        mix_out_d   = sat_val;
        clip_d      = sat_clip;
        mix_valid_d = 1'b1;
      end
      default: ;
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q     <= '0;
      acc_q     <= '0;
      voice_q   <= '0;
      mute_q    <= '0;
      mix_out   <= '0;
      clip      <= 1'b0;
      mix_valid <= 1'b0;
      overrun   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      idx_q     <= idx_d;
      acc_q     <= acc_d;
      voice_q   <= voice_d;
      mute_q    <= mute_d;
      mix_out   <= mix_out_d;
      clip      <= clip_d;
      mix_valid <= mix_valid_d;
      overrun   <= overrun_d;
      busy      <= busy_d;
    end
  end

endmodule

// File: tb/tb_voice_mixer.sv
// Directed bench: three mixer builds (unipolar 8-bit, bipolar 8-bit, bipolar 6-bit)
// share one stimulus stream; all expected values are hand-computed.
module tb_voice_mixer;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] voice_in, mute;
  logic       sample_tick, vol_we;
  logic [2:0] vol_addr;
  logic [3:0] vol_data;

  logic [7:0] u_out, b8_out;
  logic [5:0] b6_out;
  logic       u_valid, u_clip, u_busy, u_ovr;
  logic       b8_valid, b8_clip, b8_busy, b8_ovr;
  logic       b6_valid, b6_clip, b6_busy, b6_ovr;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  voice_mixer #(.NUM_VOICES(5), .VOL_W(4), .OUT_W(8), .BIPOLAR(1'b0)) u_uni (
    .clk(clk), .rst(rst), .voice_in(voice_in), .mute(mute), .sample_tick(sample_tick),
    .vol_we(vol_we), .vol_addr(vol_addr), .vol_data(vol_data),
    .mix_out(u_out), .mix_valid(u_valid), .clip(u_clip), .busy(u_busy), .overrun(u_ovr));

  voice_mixer #(.NUM_VOICES(5), .VOL_W(4), .OUT_W(8), .BIPOLAR(1'b1)) u_bip8 (
    .clk(clk), .rst(rst), .voice_in(voice_in), .mute(mute), .sample_tick(sample_tick),
    .vol_we(vol_we), .vol_addr(vol_addr), .vol_data(vol_data),
    .mix_out(b8_out), .mix_valid(b8_valid), .clip(b8_clip), .busy(b8_busy), .overrun(b8_ovr));

  voice_mixer #(.NUM_VOICES(5), .VOL_W(4), .OUT_W(6), .BIPOLAR(1'b1)) u_bip6 (
    .clk(clk), .rst(rst), .voice_in(voice_in), .mute(mute), .sample_tick(sample_tick),
    .vol_we(vol_we), .vol_addr(vol_addr), .vol_data(vol_data),
    .mix_out(b6_out), .mix_valid(b6_valid), .clip(b6_clip), .busy(b6_busy), .overrun(b6_ovr));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_vol(input logic [2:0] a, input logic [3:0] d);
    vol_we = 1'b1; vol_addr = a; vol_data = d;
    step();
    vol_we = 1'b0;
  endtask

  task automatic all_vols(input logic [3:0] d);
    for (int i = 0; i < 5; i++) write_vol(3'(i), d);
  endtask

  // Tick sampled at edge T; returns in cycle T.
  task automatic mix_start();
    sample_tick = 1'b1;
    step();
    sample_tick = 1'b0;
  endtask

  // From cycle T: mix_valid stays low through T+5 and rises in T+6.
  task automatic mix_finish(input string tag);
    logic early;
    early = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      early = early | u_valid | b8_valid | b6_valid;
    end
    check({tag, " no early valid"}, 32'(early), 32'd0);
    step();
    check({tag, " valid"}, 32'({u_valid, b8_valid, b6_valid}), 32'b111);
  endtask

  initial begin
    logic seen;
    rst = 1'b1; voice_in = '0; mute = '0; sample_tick = 1'b0;
    vol_we = 1'b0; vol_addr = '0; vol_data = '0;
    step(); step();
    check("reset out",    32'({u_out, b8_out, 2'b00, b6_out}), 32'd0);
    check("reset status", 32'({u_valid, u_clip, u_busy, u_ovr, b6_clip, b6_busy}), 32'd0);
    rst = 1'b0;
    step();

    // All voices high, default volumes 15.
    voice_in = 5'b11111;
    mix_start();
    check("busy at start", 32'(u_busy), 32'd1);
    mix_finish("allhigh");
    check("allhigh uni out",  32'(u_out),  32'h4B);
    check("allhigh uni clip", 32'(u_clip), 32'd0);
    check("allhigh bip8 out", 32'(b8_out), 32'h4B);
    check("allhigh bip6 out", 32'(b6_out), 32'h1F);
    check("allhigh bip6 clip", 32'(b6_clip), 32'd1);
    step();
    check("valid one cycle", 32'(u_valid), 32'd0);
    check("idle after done", 32'(u_busy), 32'd0);
    check("out holds", 32'(u_out), 32'h4B);

    // All voices low: bipolar drives negative.
    voice_in = 5'b00000;
    mix_start();
    mix_finish("alllow");
    check("alllow uni out",   32'(u_out),   32'h00);
    check("alllow bip8 out",  32'(b8_out),  32'hB5);
    check("alllow bip8 clip", 32'(b8_clip), 32'd0);
    check("alllow bip6 out",  32'(b6_out),  32'h20);
    check("alllow bip6 clip", 32'(b6_clip), 32'd1);

    // Volumes 1..5, voices 0..2 high; out-of-range writes dropped.
    for (int i = 0; i < 5; i++) write_vol(3'(i), 4'(i + 1));
    write_vol(3'd5, 4'd0);
    write_vol(3'd7, 4'd0);
    voice_in = 5'b00111;
    mix_start();
    mix_finish("weighted");
    check("weighted uni out",  32'(u_out),  32'h06);
    check("weighted bip8 out", 32'(b8_out), 32'hFD);
    check("weighted bip6 out", 32'(b6_out), 32'h3D);
    check("weighted clip",     32'({u_clip, b8_clip, b6_clip}), 32'd0);

    // Mutes with voice/mute changes after the snapshot.
    all_vols(4'd15);
    voice_in = 5'b11111; mute = 5'b00011;
    mix_start();
    voice_in = 5'b00000; mute = 5'b00000;
    mix_finish("mute");
    check("mute uni out", 32'(u_out), 32'h2D);

    // Writes while busy: voice 0 written in its own read cycle keeps old value,
    // voice 4 written early takes effect.
    voice_in = 5'b11111;
    mix_start();
    vol_we = 1'b1; vol_addr = 3'd0; vol_data = 4'd0;
    step();
    vol_addr = 3'd4;
    step();
    vol_we = 1'b0;
    for (int i = 0; i < 3; i++) step();
    check("busywr no early valid", 32'(u_valid), 32'd0);
    step();
    check("busywr valid", 32'(u_valid), 32'd1);
    check("busywr uni out", 32'(u_out), 32'h3C);
    mix_start();
    mix_finish("newvol");
    check("newvol uni out", 32'(u_out), 32'h2D);
    all_vols(4'd15);

    // Overrun: second tick inside the mix is ignored.
    mix_start();
    step();
    sample_tick = 1'b1;
    step();
    sample_tick = 1'b0;
    check("overrun pulse", 32'({u_ovr, u_busy}), 32'b11);
    step();
    check("overrun clears", 32'(u_ovr), 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      seen = seen | u_valid;
    end
    check("overrun no early valid", 32'(seen), 32'd0);
    step();
    check("overrun single valid", 32'(u_valid), 32'd1);
    check("overrun out", 32'(u_out), 32'h4B);
    mix_start();
    check("back-to-back accepted", 32'({u_busy, u_ovr, u_valid}), 32'b100);
    mix_finish("b2b");
    check("b2b out", 32'(u_out), 32'h4B);

    // Reset mid-accumulation aborts and restores volumes.
    all_vols(4'd3);
    mix_start();
    step(); step();
    rst = 1'b1;
    step();
    check("rst out",    32'({u_out, b8_out, 2'b00, b6_out}), 32'd0);
    check("rst status", 32'({u_valid, u_busy, u_clip, b6_clip}), 32'd0);
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      seen = seen | u_valid | u_busy;
    end
    check("rst no valid", 32'(seen), 32'd0);
    mix_start();
    mix_finish("postrst");
    check("postrst uni out", 32'(u_out), 32'h4B);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
